// File: rtl/pc_unit.sv
// Fetch-stage program counter with sequential advance, trap/load/return redirects,
// alignment rejection of load targets, and a circular return-address stack.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = {WIDTH{1'b0}},
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          en_i,
    input  logic                          load_i,
    input  logic [WIDTH-1:0]              target_i,
    input  logic                          call_i,
    input  logic                          ret_i,
    input  logic                          trap_i,
    input  logic [WIDTH-1:0]              trap_vector_i,
    output logic [WIDTH-1:0]              pc_o,
    output logic [WIDTH-1:0]              pc_plus_4_o,
    output logic                          misaligned_o,
    output logic                          ret_miss_o,
    output logic [$clog2(RAS_DEPTH):0]    ras_count_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    function automatic logic is_word_aligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misaligned_q, misaligned_d;
    logic             ret_miss_q, ret_miss_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus_4_s;
    logic [WIDTH-1:0] trap_target_s;
    logic             push_s;
    logic             pop_s;
    logic             ras_empty_s;
    logic             unused_tv_s;

    assign pc_plus_4_s   = pc_q + PC_STEP;
    assign trap_target_s = {trap_vector_i[WIDTH-1:2], 2'b00};
    assign ras_empty_s   = (count_q == {CNT_W{1'b0}});
    assign unused_tv_s   = ^trap_vector_i[1:0];

    // Next-pc selection and redirect classification, highest priority first
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        ret_miss_d   = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        if (trap_i) begin
            pc_d = trap_target_s;
        end else if (en_i) begin
            if (load_i) begin
                if (is_word_aligned(target_i)) begin
                    pc_d   = target_i;
                    push_s = call_i;
                end else begin
                    misaligned_d = 1'b1;
                end
            end else if (ret_i) begin
                if (!ras_empty_s) begin
                    pc_d  = ras_q[top_q];
                    pop_s = 1'b1;
                end else begin
                    pc_d       = pc_plus_4_s;
                    ret_miss_d = 1'b1;
                end
            end else begin
                pc_d = pc_plus_4_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // RAS pointer and occupancy; a full push overwrites the oldest slot
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (trap_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (push_s) begin
            top_d = top_q + PTR_ONE;
            if (count_q == RAS_FULL) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop_s) begin
            top_d   = top_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end else begin
            top_d   = top_q;
            count_d = count_q;
        end
    end

    // Control state: pc, RAS pointer/count and the one-cycle status pulses
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pc_q         <= RESET_VECTOR;
            top_q        <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            misaligned_q <= 1'b0;
            ret_miss_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            top_q        <= top_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
            ret_miss_q   <= ret_miss_d;
        end
    end

    // RAS storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge clk_i) begin
        if (reset_n_i && push_s && !trap_i) begin
            ras_q[top_d] <= pc_plus_4_s;
        end
    end

    assign pc_o         = pc_q;
    assign pc_plus_4_o  = pc_plus_4_s;
    assign misaligned_o = misaligned_q;
    assign ret_miss_o   = ret_miss_q;
    assign ras_count_o  = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit (WIDTH=32, RESET_VECTOR=0, RAS_DEPTH=4).
module tb_pc_unit;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        mis;
        logic        rmiss;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, en, load, call, ret, trap;
    logic [31:0] target, trap_vector;
    logic [31:0] pc, pc_plus_4;
    logic        misaligned, ret_miss;
    logic [2:0]  ras_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .load_i(load),
        .target_i(target), .call_i(call), .ret_i(ret), .trap_i(trap),
        .trap_vector_i(trap_vector), .pc_o(pc), .pc_plus_4_o(pc_plus_4),
        .misaligned_o(misaligned), .ret_miss_o(ret_miss), .ras_count_o(ras_count)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rst_n_v, input logic en_v,
                        input logic load_v, input logic call_v, input logic ret_v,
                        input logic trap_v, input logic [31:0] tgt_v, input logic [31:0] tv_v,
                        input logic [31:0] e_pc, input logic [2:0] e_cnt,
                        input logic e_mis, input logic e_rmiss);
        exp_t e;
        @(negedge clk);
        reset_n = rst_n_v; en = en_v; load = load_v; call = call_v;
        ret = ret_v; trap = trap_v; target = tgt_v; trap_vector = tv_v;
        e.tag = tag; e.pc = e_pc; e.cnt = e_cnt; e.mis = e_mis; e.rmiss = e_rmiss;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (pc === e.pc) else begin
            errors++; $error("FAIL %s pc observed %h expected %h", e.tag, pc, e.pc);
        end
        checks++;
        assert (pc_plus_4 === e.pc + 32'd4) else begin
            errors++; $error("FAIL %s pc_plus_4 observed %h expected %h", e.tag, pc_plus_4, e.pc + 32'd4);
        end
        checks++;
        assert (ras_count === e.cnt) else begin
            errors++; $error("FAIL %s ras_count observed %0d expected %0d", e.tag, ras_count, e.cnt);
        end
        checks++;
        assert (misaligned === e.mis) else begin
            errors++; $error("FAIL %s misaligned observed %b expected %b", e.tag, misaligned, e.mis);
        end
        checks++;
        assert (ret_miss === e.rmiss) else begin
            errors++; $error("FAIL %s ret_miss observed %b expected %b", e.tag, ret_miss, e.rmiss);
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; trap = 1'b0;
        target = 32'h0; trap_vector = 32'h0;

        // Reset, stall, then sequential advance
        step("reset0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        step("reset1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++)
            step("advance", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'(4 * i), 3'd0, 1'b0, 1'b0);

        // Misaligned reject then aligned load
        step("misalign", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00c0ffee, 32'h0, 32'h10, 3'd0, 1'b1, 1'b0);
        step("aligned",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00c0ffec, 32'h0, 32'h00c0ffec, 3'd0, 1'b0, 1'b0);

        // Call and return
        step("to100",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h100, 3'd0, 1'b0, 1'b0);
        step("call400", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h400, 3'd1, 1'b0, 1'b0);
        step("adv404",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h404, 3'd1, 1'b0, 1'b0);
        step("adv408",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h408, 3'd1, 1'b0, 1'b0);
        step("ret104",  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h104, 3'd0, 1'b0, 1'b0);

        // Overflow: calls from 0x0..0x40, then six returns
        step("to0",     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            step("callovf", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'(16 * i), 32'h0,
                 32'(16 * i), (i > 4) ? 3'd4 : 3'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("retovf", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,
                 32'h44 - 32'(16 * i), 3'(3 - i), 1'b0, 1'b0);
        step("retmiss5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h18, 3'd0, 1'b0, 1'b1);
        step("retmiss6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1c, 3'd0, 1'b0, 1'b1);
        step("stallld",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h201, 32'h0, 32'h1c, 3'd0, 1'b0, 1'b0);
        step("adv20",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20, 3'd0, 1'b0, 1'b0);

        // Trap beats load/ret during stall and flushes the RAS
        step("call100", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h100, 3'd1, 1'b0, 1'b0);
        step("call200", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h200, 3'd2, 1'b0, 1'b0);
        step("trap",    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h80000003, 32'h80000000, 3'd0, 1'b0, 1'b0);
        step("retflush",1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h80000004, 3'd0, 1'b0, 1'b1);

        // Wrap, then reset during a misaligned load with a non-empty RAS
        step("toFFFC",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 3'd0, 1'b0, 1'b0);
        step("wrap",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        step("call300", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h300, 3'd1, 1'b0, 1'b0);
        step("rstld",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h501, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        step("postrst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the fetch stage, replacing the fixed 32-bit enable/load counter. It holds the current fetch address, advances by 4 each enabled cycle, accepts redirects from execute and the trap logic, and keeps a small circular return-address stack (RAS) so that returns can be redirected without a computed target. It checks redirect targets for alignment and rejects misaligned targets.

## Interface
- `WIDTH`, 32: address width in bits; minimum 8.
- `RESET_VECTOR`, 0: value loaded into `pc` on reset; must be 4-byte aligned.
- `RAS_DEPTH`, 4: number of RAS entries; power of two, 2 to 16.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `en`  in  1  advance or redirect enable; the stall is `en`=0.
- `load`  in  1  redirect to `target`; qualified by `en`.
- `target`  in  WIDTH  redirect address for `load`.
- `call`  in  1  with an accepted `load`, pushes `pc_plus_4` onto the RAS.
- `ret`  in  1  redirect to the RAS top and pop; qualified by `en`.
- `trap`  in  1  redirect to `trap_vector`; not qualified by `en`.
- `trap_vector`  in  WIDTH  trap redirect address; low 2 bits ignored (treated as 0).
- `pc`  out  WIDTH  current fetch address, registered.
- `pc_plus_4`  out  WIDTH  `pc` + 4, combinational, wraps modulo 2^WIDTH.
- `misaligned`  out  1  registered one-cycle pulse: a `load` was rejected.
- `ret_miss`  out  1  registered one-cycle pulse: a `ret` found the RAS empty.
- `ras_count`  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.

## Operation
- Next-`pc` priority, highest first:
  1. Reset.
  2. `trap`.
  3. `en` with `load`.
  4. `en` with `ret`.
  5. `en` alone.
  6. Hold.
- Reset (`reset_n`=0 at edge):
  - `pc` = RESET_VECTOR.
  - `ras_count` = 0.
  - `misaligned` = 0 and `ret_miss` = 0.
  - Overrides every other input.
- Trap:
  - `pc` = {`trap_vector`[WIDTH-1:2], 2'b00}.
  - RAS flushed: `ras_count` = 0.
  - `load`, `ret` and `call` are ignored that cycle.
- Load with `target`[1:0] == 0:
  - `pc` = `target`.
  - If `call` is also set, push the pre-update `pc_plus_4`.
- Load with `target`[1:0] != 0:
  - `pc` holds and there is no push.
  - `misaligned` = 1 next cycle.
- Ret, `ras_count` > 0:
  - `pc` = RAS top.
  - Pop: `ras_count` decrements.
- Ret, `ras_count` == 0:
  - `pc` = `pc_plus_4`.
  - `ret_miss` = 1 next cycle.
- `load` and `ret` together: `load` wins and there is no pop.
- `call` without an accepted `load` has no effect.
- Sequential advance: `pc` = `pc_plus_4`, including wrap from 2^WIDTH-4 to 0.
- RAS structure:
  - Circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; `ras_count` saturates at RAS_DEPTH.
  - Pop after an overflow returns the newest entries, in order.
  - Pop of an empty RAS never moves the pointer.
- `en`=0 with no trap:
  - `pc` and the RAS hold.
  - `load`, `ret` and `call` are ignored.
  - No pulses are produced.

## Timing
- Every redirect and advance is visible on `pc` one cycle after the qualifying edge. There are no bubbles and no multi-cycle states.
- `pc_plus_4` follows `pc` in the same cycle.
- `misaligned` and `ret_miss`:
  - Assert for exactly one cycle, in the cycle after the triggering edge.
  - Deassert the cycle after that unless retriggered.
- RAS push and pop take effect at the same edge as the `pc` update. `ras_count` reflects the edge result.
- Reset during a stall, trap or full RAS: the reset values above appear the next cycle. No pending pulse survives reset.

## Test plan
- Reset and stall:
  - Stimulus: WIDTH=32, RESET_VECTOR=0, hold `reset_n`=0 for 2 cycles, then release with `en`=0 for 3 cycles, then `en`=1.
  - Required: `pc` = 0 throughout the stall, then 4, 8, 12 on successive cycles; `pc_plus_4` = `pc`+4 at all times.
- Misaligned reject:
  - Stimulus: `en`=1 with `pc`=0x10, pulse `load` with `target`=0x00c0ffee.
  - Required: `pc` stays 0x10 and `misaligned`=1 for one cycle.
  - Follow-up stimulus: `load` with `target`=0x00c0ffec.
  - Required: `pc`=0x00c0ffec next cycle and `misaligned`=0.
- Call and return:
  - Stimulus: at `pc`=0x100, `load`+`call` with `target`=0x400; advance 2 cycles; pulse `ret`.
  - Required: `pc` = 0x400, then 0x404, 0x408, then 0x104; `ras_count` goes 1 then 0.
- RAS overflow and empty:
  - Stimulus: RAS_DEPTH=4, issue 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40, then 6 rets.
  - Required: `ras_count` saturates at 4; rets return 0x44, 0x34, 0x24, 0x14; the 5th and 6th rets advance sequentially and pulse `ret_miss`.
- Trap priority:
  - Stimulus: `trap`, `load` and `ret` together with `en`=0, `trap_vector`=0x80000003, `ras_count`=2.
  - Required: `pc`=0x80000000 next cycle and `ras_count`=0.
- Wrap and reset mid-operation:
  - Stimulus: `pc`=0xFFFFFFFC with `en`=1.
  - Required: `pc`=0 next cycle.
  - Stimulus: assert `reset_n`=0 in the same cycle as `load`.
  - Required: `pc`=RESET_VECTOR and `ras_count`=0.
